// File: rtl/fetch_pkg.sv
// Shared constants, counter encodings and BTB geometry helpers for the fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bp_ctr_e;

    // Word-aligned PCs: bits [1:0] never reach the BTB, so index+tag cover 30 bits.
    function automatic int btb_idx_width(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int btb_tag_width(input int entries);
        return 30 - $clog2(entries);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: decode control, BTB update strobe, instruction memory port and fetch outputs.
interface fetch_if;

    logic        decode_stall;
    logic        decode_flush;
    logic [31:0] redirect_pc;
    logic        btb_update_valid;
    logic [31:0] btb_update_pc;
    logic [31:0] btb_update_target;
    logic        btb_update_taken;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_predicted_pc;

    modport master (
        input  decode_stall,
        input  decode_flush,
        input  redirect_pc,
        input  btb_update_valid,
        input  btb_update_pc,
        input  btb_update_target,
        input  btb_update_taken,
        output imem_addr,
        input  imem_rdata,
        output fetch_pc,
        output fetch_inst,
        output fetch_predicted_pc
    );

    modport slave (
        output decode_stall,
        output decode_flush,
        output redirect_pc,
        output btb_update_valid,
        output btb_update_pc,
        output btb_update_target,
        output btb_update_taken,
        input  imem_addr,
        output imem_rdata,
        input  fetch_pc,
        input  fetch_inst,
        input  fetch_predicted_pc
    );

endinterface

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] lookup_pc,
    output logic        lookup_hit,
    output logic [31:0] predicted_pc,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken
);

    localparam int IW = btb_idx_width(ENTRIES);
    localparam int TW = btb_tag_width(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    bp_ctr_e            ctr_q    [ENTRIES];

    logic [IW-1:0] lk_idx;
    logic [TW-1:0] lk_tag;
    logic [IW-1:0] up_idx;
    logic [TW-1:0] up_tag;
    logic          up_hit;
    logic          unused_update_bits;

    assign lk_idx = lookup_pc[2 +: IW];
    assign lk_tag = lookup_pc[31 -: TW];
    assign up_idx = update_pc[2 +: IW];
    assign up_tag = update_pc[31 -: TW];
    assign unused_update_bits = ^update_pc[1:0];

    // Lookup reads the arrays as they stood before this cycle's update.
    assign lookup_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign predicted_pc = (lookup_hit && (ctr_q[lk_idx] == WT || ctr_q[lk_idx] == ST))
                          ? target_q[lk_idx] : lookup_pc + 32'd4;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= '0;
        end else if (update_valid && update_taken && !up_hit) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Payload is only trusted behind a valid bit, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (update_valid) begin
            if (up_hit) begin
                if (update_taken) begin
                    target_q[up_idx] <= update_target;
                    if (ctr_q[up_idx] != ST) begin
                        ctr_q[up_idx] <= bp_ctr_e'(ctr_q[up_idx] + 2'd1);
                    end
                end else if (ctr_q[up_idx] != SNT) begin
                    ctr_q[up_idx] <= bp_ctr_e'(ctr_q[up_idx] - 2'd1);
                end
            end else if (update_taken) begin
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= update_target;
                ctr_q[up_idx]    <= WT;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle-latency instruction memory and predicts via the BTB.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic     i_clk,
    input  logic     i_reset,
    fetch_if.master  bus
);

    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] pred_pc;
    logic [31:0] next_pc;
    logic        unused_btb_hit;

    fetch_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .lookup_pc     (pc_q),
        .lookup_hit    (unused_btb_hit),
        .predicted_pc  (pred_pc),
        .update_valid  (bus.btb_update_valid),
        .update_pc     (bus.btb_update_pc),
        .update_target (bus.btb_update_target),
        .update_taken  (bus.btb_update_taken)
    );

    // Stall re-reads pc_q so the synchronous memory keeps returning the same word.
    always_comb begin
        next_pc = pred_pc;
        if (!valid_q) begin
            next_pc = pc_q;
        end else if (bus.decode_flush) begin
            next_pc = bus.redirect_pc;
        end else if (bus.decode_stall) begin
            next_pc = pc_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= next_pc;
            valid_q <= 1'b1;
        end
    end

    assign bus.imem_addr          = next_pc;
    assign bus.fetch_pc           = valid_q ? pc_q : 32'h0;
    assign bus.fetch_inst         = valid_q ? bus.imem_rdata : NOP_INST;
    assign bus.fetch_predicted_pc = valid_q ? pred_pc : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors plus a cycle-by-cycle comparison against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          N        = 16;
    localparam int          IW       = $clog2(N);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_stage #(
        .RESET_PC    (RESET_PC),
        .BTB_ENTRIES (N)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    // Synchronous instruction memory, one cycle of read latency.
    always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

    // Behavioural model: PC, valid flag and a BTB held as plain arrays.
    bit          m_valid;
    logic [31:0] m_pc;
    bit          bv   [N];
    logic [31:0] btag [N];
    logic [31:0] btgt [N];
    int          bctr [N];

    function automatic int idx_of(input logic [31:0] p);
        return int'((p >> 2) % N);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] p);
        return p >> (2 + IW);
    endfunction

    function automatic logic [31:0] model_pred(input logic [31:0] p);
        int i;
        i = idx_of(p);
        if (bv[i] && btag[i] == tag_of(p) && bctr[i] >= 2) return btgt[i];
        return p + 32'd4;
    endfunction

    function automatic logic [31:0] model_addr();
        if (!m_valid) return m_pc;
        if (bus.decode_flush) return bus.redirect_pc;
        if (bus.decode_stall) return m_pc;
        return model_pred(m_pc);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0;
            m_pc    = RESET_PC;
            for (int k = 0; k < N; k++) bv[k] = 1'b0;
        end else begin
            logic [31:0] nxt;
            int i;
            nxt = model_addr();
            i   = idx_of(bus.btb_update_pc);
            if (bus.btb_update_valid) begin
                if (bv[i] && btag[i] == tag_of(bus.btb_update_pc)) begin
                    if (bus.btb_update_taken) begin
                        bctr[i] = (bctr[i] == 3) ? 3 : bctr[i] + 1;
                        btgt[i] = bus.btb_update_target;
                    end else begin
                        bctr[i] = (bctr[i] == 0) ? 0 : bctr[i] - 1;
                    end
                end else if (bus.btb_update_taken) begin
                    bv[i]   = 1'b1;
                    btag[i] = tag_of(bus.btb_update_pc);
                    btgt[i] = bus.btb_update_target;
                    bctr[i] = 2;
                end
            end
            m_pc    = nxt;
            m_valid = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model.imem_addr", bus.imem_addr,          model_addr());
        chk("model.fetch_pc",  bus.fetch_pc,           m_valid ? m_pc : 32'h0);
        chk("model.inst",      bus.fetch_inst,         m_valid ? mem_word(m_pc) : 32'h0);
        chk("model.pred",      bus.fetch_predicted_pc, m_valid ? model_pred(m_pc) : 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit stall, input bit flush, input logic [31:0] redir,
                         input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                         input bit ut);
        bus.decode_stall      = stall;
        bus.decode_flush      = flush;
        bus.redirect_pc       = redir;
        bus.btb_update_valid  = uv;
        bus.btb_update_pc     = upc;
        bus.btb_update_target = utgt;
        bus.btb_update_taken  = ut;
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] pc,
                                input logic [31:0] pred, input logic [31:0] addr);
        @(negedge clk);
        chk({tag, ".pc"},   bus.fetch_pc,           pc);
        chk({tag, ".inst"}, bus.fetch_inst,         mem_word(pc));
        chk({tag, ".pred"}, bus.fetch_predicted_pc, pred);
        chk({tag, ".addr"}, bus.imem_addr,          addr);
    endtask

    task automatic expect_zero(input string tag, input logic [31:0] addr);
        chk({tag, ".pc"},   bus.fetch_pc,           32'h0);
        chk({tag, ".inst"}, bus.fetch_inst,         32'h0);
        chk({tag, ".pred"}, bus.fetch_predicted_pc, 32'h0);
        chk({tag, ".addr"}, bus.imem_addr,          addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        #1 reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        expect_zero("in_reset", 32'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        expect_zero("bubble", 32'h0);
        tick();

        expect_fetch("seq0", 32'h0, 32'h4, 32'h4);                     tick();
        expect_fetch("seq1", 32'h4, 32'h8, 32'h8);                     tick();
        drive(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        expect_fetch("stall1", 32'h8, 32'hC, 32'h8);                   tick();
        expect_fetch("stall2", 32'h8, 32'hC, 32'h8);                   tick();
        expect_fetch("stall3", 32'h8, 32'hC, 32'h8);                   tick();
        drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        expect_fetch("stall_rel", 32'h8, 32'hC, 32'hC);                tick();

        drive(1, 1, 32'h100, 0, 32'h0, 32'h0, 0);
        expect_fetch("flush_stall", 32'hC, 32'h10, 32'h100);           tick();
        drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        expect_fetch("redir", 32'h100, 32'h104, 32'h104);              tick();

        drive(0, 1, 32'h50, 1, 32'h10, 32'h40, 1);
        expect_fetch("alloc", 32'h104, 32'h108, 32'h50);               tick();
        drive(0, 1, 32'h10, 0, 32'h0, 32'h0, 0);
        expect_fetch("alias", 32'h50, 32'h54, 32'h10);                 tick();
        drive(0, 0, 32'h0, 1, 32'h10, 32'h0, 0);
        expect_fetch("same_cycle", 32'h10, 32'h40, 32'h40);            tick();
        drive(0, 1, 32'h10, 0, 32'h0, 32'h0, 0);
        expect_fetch("btb_target", 32'h40, 32'h44, 32'h10);            tick();

        drive(0, 1, 32'h10, 1, 32'h10, 32'h0, 0);
        expect_fetch("ctr1", 32'h10, 32'h14, 32'h10);                  tick();
        drive(0, 1, 32'h10, 1, 32'h10, 32'h80, 1);
        expect_fetch("ctr0", 32'h10, 32'h14, 32'h10);                  tick();
        expect_fetch("ctr1_up", 32'h10, 32'h14, 32'h10);               tick();
        expect_fetch("ctr2_up", 32'h10, 32'h80, 32'h10);               tick();
        expect_fetch("ctr3", 32'h10, 32'h80, 32'h10);                  tick();
        drive(0, 1, 32'h10, 1, 32'h10, 32'h0, 0);
        expect_fetch("ctr3_sat", 32'h10, 32'h80, 32'h10);              tick();
        drive(0, 0, 32'h0, 1, 32'h10, 32'h0, 0);
        expect_fetch("ctr2_dn", 32'h10, 32'h80, 32'h80);               tick();
        drive(0, 1, 32'h10, 0, 32'h0, 32'h0, 0);
        expect_fetch("taken_tgt", 32'h80, 32'h84, 32'h10);             tick();
        drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        expect_fetch("ctr1_dn", 32'h10, 32'h14, 32'h14);               tick();

        drive(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        expect_fetch("pre_reset", 32'h14, 32'h18, 32'h14);
        #2 reset = 1'b1;
        #1;
        expect_zero("async_reset", RESET_PC);
        tick();
        tick();
        reset = 1'b0;
        drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        expect_zero("restart_bubble", RESET_PC);
        tick();
        expect_fetch("restart0", 32'h0, 32'h4, 32'h4);                 tick();
        drive(0, 1, 32'h10, 0, 32'h0, 32'h0, 0);
        expect_fetch("restart1", 32'h4, 32'h8, 32'h10);                tick();
        drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        expect_fetch("btb_cleared", 32'h10, 32'h14, 32'h14);           tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that directly feeds decode_stage. It owns the PC register and drives a synchronous instruction memory with 1-cycle read latency. It presents fetch_pc, fetch_inst and fetch_predicted_pc to decode, and predicts next PC with a small direct-mapped BTB using 2-bit saturating counters. It honours decode_stall and decode_flush, and redirects to redirect_pc on flush.

Parameters:
RESET_PC, 32'h0, byte address of first instruction fetched after reset
BTB_ENTRIES, 16, number of direct-mapped BTB entries (power of 2, >=2)

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset  input  1  asynchronous, active-high reset
decode_stall  input  1  decode not accepting; hold current outputs
decode_flush  input  1  wrong-path squash; priority over decode_stall
redirect_pc  input  32  corrected PC, meaningful only when decode_flush=1
btb_update_valid  input  1  resolved-branch update strobe
btb_update_pc  input  32  PC of resolved branch
btb_update_target  input  32  resolved taken target
btb_update_taken  input  1  resolved direction
imem_addr  output  32  byte address to instruction memory (combinational)
imem_rdata  input  32  instruction for address presented previous cycle
fetch_pc  output  32  PC of instruction on fetch_inst
fetch_inst  output  32  instruction word
fetch_predicted_pc  output  32  predicted successor of fetch_pc

Behaviour:
- State: pc_q (32), valid_q (1), BTB arrays.
- Reset (async): pc_q=RESET_PC, valid_q=0, all BTB valid bits=0. Counters, tags and targets need no reset.
- Outputs while valid_q=0: fetch_pc=0, fetch_inst=0, fetch_predicted_pc=0. This all-zero bubble matches the zeros decode writes on flush.
- Outputs while valid_q=1: fetch_pc=pc_q, fetch_inst=imem_rdata, fetch_predicted_pc=pred(pc_q).
- pred(p): BTB hit at index p[2+IW-1:2] with IW=log2(BTB_ENTRIES), tag p[31:2+IW] matches, and counter>=2 gives the stored target. Otherwise p+4, wrapping modulo 2^32.
- imem_addr selection, in priority order:
  - valid_q=0: pc_q (first fetch after reset)
  - decode_flush=1: redirect_pc
  - decode_stall=1: pc_q (re-read, so imem_rdata stays stable)
  - otherwise: pred(pc_q)
- Every clock outside reset: pc_q<=imem_addr and valid_q<=1.
- Timing consequences:
  - Exactly one bubble cycle after reset release.
  - No extra bubble after a flush: the cycle after flush presents redirect_pc's instruction with valid_q=1.
  - Flush together with stall: flush wins.
- BTB update, same edge as the strobe:
  - Tag hit: counter saturating-increments if taken, else saturating-decrements. Target is rewritten if taken.
  - Miss and taken: allocate or overwrite the entry with tag, target, counter=2'b10, valid=1.
  - Miss and not taken: no change.
- Lookup and update in the same cycle: lookup sees the pre-update contents (no bypass).
- BTB never reads or writes a bit outside pc[31:2]; pc[1:0] are ignored.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INST = 32'h0
  - the 2-bit counter encodings: SNT=0, WNT=1, WT=2, ST=3
  - the function computing index and tag widths from BTB_ENTRIES
- Sub-module fetch_btb (parameter ENTRIES) contains the arrays, the combinational lookup port (pc -> hit, predicted_pc) and the update port. fetch_stage instantiates one.

Test Plan:
- Reset with RESET_PC=0: while reset and for the first cycle after release, outputs are 0 and imem_addr=0. Next cycles give fetch_pc 0x0, 0x4, 0x8 with fetch_inst equal to the memory words.
- Stall at fetch_pc=0x8 for 3 cycles: fetch_pc stays 0x8, imem_addr stays 0x8, fetch_inst is constant. Release gives 0xC on the next cycle.
- Flush with redirect_pc=0x100 asserted together with decode_stall: next cycle fetch_pc=0x100 and valid, then 0x104.
- BTB allocate: update pc=0x10, taken, target 0x40. On the next fetch of 0x10, fetch_predicted_pc=0x40 and the following fetch_pc=0x40.
- Counter and alias:
  - Two not-taken updates at 0x10 drop the counter 2->1->0, so prediction becomes 0x14.
  - A lookup of 0x50 (same index 4, different tag) never hits, giving 0x54.
  - A same-cycle update and lookup at 0x10 returns the old prediction.
- Asynchronous reset asserted mid-stall, between clock edges: outputs go to 0 immediately. Fetch restarts at RESET_PC with one bubble, and prior BTB entries no longer hit.
